// File: rtl/zkbdmus_ng.sv
// Keyboard, mouse and joystick data hub for the zports read path.
// Latches slavespi input state and buffers key-scan events in a small FIFO.
module zkbdmus_ng #(
  parameter int ROWS       = 8,
  parameter int COLS       = 5,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 fclk,
  input  logic                 rst_n,
  input  logic [ROWS*COLS-1:0] kbd_in,
  input  logic                 kbd_stb,
  input  logic [7:0]           mus_in,
  input  logic                 mus_dxstb,
  input  logic                 mus_dystb,
  input  logic                 mus_btnstb,
  input  logic                 kj_stb,
  input  logic [7:0]           ev_in,
  input  logic                 ev_stb,
  input  logic                 ev_pop,
  input  logic [7:0]           zah,
  output logic [COLS-1:0]      kbd_data,
  output logic [7:0]           mus_data,
  output logic [4:0]           kj_data,
  output logic [7:0]           ev_data,
  output logic                 ev_empty,
  output logic                 ev_full,
  output logic                 ev_ovf
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [ROWS*COLS-1:0] kbd;
  logic [7:0]           musx;
  logic [7:0]           musy;
  logic [7:0]           musbtn;

  logic [7:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]        rdptr;
  logic [AW-1:0]        wrptr;
  logic [CW-1:0]        count;

  logic pop_ok;
  logic push_ok;
  logic push_drop;

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      kbd     <= '0;
      musx    <= 8'h00;
      musy    <= 8'h00;
      musbtn  <= 8'hFF;
      kj_data <= 5'h00;
    end else begin
      if (kbd_stb)    kbd     <= kbd_in;
      if (mus_dxstb)  musx    <= musx + mus_in;
      if (mus_dystb)  musy    <= musy + mus_in;
      if (mus_btnstb) musbtn  <= mus_in;
      if (kj_stb)     kj_data <= mus_in[4:0];
    end
  end

  // A full FIFO still takes a push when a pop frees a slot in the same cycle.
  always_comb begin
    pop_ok    = ev_pop && (count != '0);
    push_ok   = ev_stb && ((count != CW'(FIFO_DEPTH)) || pop_ok);
    push_drop = ev_stb && !push_ok;
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      rdptr  <= '0;
      wrptr  <= '0;
      count  <= '0;
      ev_ovf <= 1'b0;
    end else begin
      if (pop_ok)  rdptr <= rdptr + AW'(1);
      if (push_ok) wrptr <= wrptr + AW'(1);
      if (push_ok && !pop_ok)      count <= count + CW'(1);
      else if (pop_ok && !push_ok) count <= count - CW'(1);
      if (push_drop)   ev_ovf <= 1'b1;
      else if (pop_ok) ev_ovf <= 1'b0;
    end
  end

  // Storage has no reset; clearing the pointers and count discards it.
  always_ff @(posedge fclk) begin
    if (push_ok) mem[wrptr] <= ev_in;
  end

  assign ev_empty = (count == '0);
  assign ev_full  = (count == CW'(FIFO_DEPTH));
  assign ev_data  = ev_empty ? 8'h00 : mem[rdptr];

  always_comb begin
    kbd_data = '1;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (!zah[r] && kbd[r + ROWS*c]) kbd_data[COLS-1-c] = 1'b0;
      end
    end
  end

  always_comb begin
    if (!zah[0])     mus_data = musbtn;
    else if (!zah[2]) mus_data = musx;
    else              mus_data = musy;
  end

endmodule

// File: tb/tb_zkbdmus_ng.sv
// Scoreboard bench for zkbdmus_ng: stimulus pushes model predictions,
// a negedge monitor pops and compares them with the DUT outputs.
module tb_zkbdmus_ng;

  localparam int ROWS  = 8;
  localparam int COLS  = 5;
  localparam int DEPTH = 8;

  logic                 fclk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [ROWS*COLS-1:0] kbd_in = '0;
  logic                 kbd_stb = 1'b0;
  logic [7:0]           mus_in = 8'h00;
  logic                 mus_dxstb = 1'b0;
  logic                 mus_dystb = 1'b0;
  logic                 mus_btnstb = 1'b0;
  logic                 kj_stb = 1'b0;
  logic [7:0]           ev_in = 8'h00;
  logic                 ev_stb = 1'b0;
  logic                 ev_pop = 1'b0;
  logic [7:0]           zah = 8'h00;
  logic [COLS-1:0]      kbd_data;
  logic [7:0]           mus_data;
  logic [4:0]           kj_data;
  logic [7:0]           ev_data;
  logic                 ev_empty;
  logic                 ev_full;
  logic                 ev_ovf;

  zkbdmus_ng #(.ROWS(ROWS), .COLS(COLS), .FIFO_DEPTH(DEPTH)) dut (
    .fclk(fclk), .rst_n(rst_n), .kbd_in(kbd_in), .kbd_stb(kbd_stb),
    .mus_in(mus_in), .mus_dxstb(mus_dxstb), .mus_dystb(mus_dystb),
    .mus_btnstb(mus_btnstb), .kj_stb(kj_stb), .ev_in(ev_in),
    .ev_stb(ev_stb), .ev_pop(ev_pop), .zah(zah), .kbd_data(kbd_data),
    .mus_data(mus_data), .kj_data(kj_data), .ev_data(ev_data),
    .ev_empty(ev_empty), .ev_full(ev_full), .ev_ovf(ev_ovf)
  );

  always #5 fclk = ~fclk;

  typedef struct {
    logic [COLS-1:0] kd;
    logic [7:0]      md;
    logic [4:0]      kj;
    logic [7:0]      ed;
    logic            em;
    logic            fu;
    logic            ov;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fails  = 0;

  // Reference model: plain key grid, byte accumulators and a byte queue.
  bit         kb [ROWS][COLS];
  logic [7:0] mx, my, mb;
  logic [4:0] mkj;
  logic [7:0] fq[$];
  bit         movf;

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) kb[r][c] = 1'b0;
    mx = 8'h00; my = 8'h00; mb = 8'hFF; mkj = 5'h00;
    fq.delete();
    movf = 1'b0;
  endtask

  function automatic exp_t model_outputs(logic [7:0] z);
    exp_t e;
    for (int c = 0; c < COLS; c++) begin
      bit any = 1'b0;
      for (int r = 0; r < ROWS; r++) if (z[r] == 1'b0 && kb[r][c]) any = 1'b1;
      e.kd[COLS-1-c] = !any;
    end
    if (z[0] == 1'b0)      e.md = mb;
    else if (z[2] == 1'b0) e.md = mx;
    else                   e.md = my;
    e.kj = mkj;
    e.em = (fq.size() == 0);
    e.fu = (fq.size() == DEPTH);
    e.ed = (fq.size() == 0) ? 8'h00 : fq[0];
    e.ov = movf;
    return e;
  endfunction

  task automatic check_output(string nm, string field, logic [7:0] act, logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("[TB] FAIL %s.%s got %h expected %h", nm, field, act, req);
    end
  endtask

  always @(negedge fclk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check_output(nm, "kbd_data", 8'(kbd_data), 8'(e.kd));
      check_output(nm, "mus_data", mus_data, e.md);
      check_output(nm, "kj_data", 8'(kj_data), 8'(e.kj));
      check_output(nm, "ev_data", ev_data, e.ed);
      check_output(nm, "ev_empty", 8'(ev_empty), 8'(e.em));
      check_output(nm, "ev_full", 8'(ev_full), 8'(e.fu));
      check_output(nm, "ev_ovf", 8'(ev_ovf), 8'(e.ov));
    end
  end

  task automatic apply_stimulus(input logic [ROWS*COLS-1:0] k, input logic ks,
                                input logic [7:0] m, input logic dx, input logic dy,
                                input logic bs, input logic kjs, input logic [7:0] e,
                                input logic es, input logic ep, input logic [7:0] z,
                                input string nm);
    bit pop_ok, push_ok;
    @(posedge fclk);
    #1;
    kbd_in = k; kbd_stb = ks; mus_in = m; mus_dxstb = dx; mus_dystb = dy;
    mus_btnstb = bs; kj_stb = kjs; ev_in = e; ev_stb = es; ev_pop = ep; zah = z;
    exp_q.push_back(model_outputs(z));
    name_q.push_back(nm);
    if (ks)
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) kb[r][c] = k[r + ROWS*c];
    if (dx)  mx = mx + m;
    if (dy)  my = my + m;
    if (bs)  mb = m;
    if (kjs) mkj = m[4:0];
    pop_ok  = ep && (fq.size() > 0);
    push_ok = es && ((fq.size() < DEPTH) || pop_ok);
    if (pop_ok)  void'(fq.pop_front());
    if (push_ok) fq.push_back(e);
    if (es && !push_ok) movf = 1'b1;
    else if (pop_ok)    movf = 1'b0;
  endtask

  task automatic idle(input logic [7:0] z, input string nm);
    apply_stimulus('0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, z, nm);
  endtask

  task automatic fifo_op(input logic [7:0] e, input logic es, input logic ep, input string nm);
    apply_stimulus('0, 0, 8'h00, 0, 0, 0, 0, e, es, ep, 8'hFF, nm);
  endtask

  initial begin
    logic [ROWS*COLS-1:0] k;
    model_reset();
    repeat (2) @(posedge fclk);
    #1 rst_n = 1'b1;

    idle(8'h00, "reset_state");

    k = '0; k[0] = 1'b1; k[9] = 1'b1;
    apply_stimulus(k, 1, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 8'hFF, "kbd_load");
    idle(8'hFE, "kbd_row0");
    idle(8'hFD, "kbd_row1");
    idle(8'hFC, "kbd_rows01");

    apply_stimulus('0, 0, 8'h05, 1, 0, 0, 0, 8'h00, 0, 0, 8'hFB, "dx_05");
    apply_stimulus('0, 0, 8'hFA, 1, 0, 0, 0, 8'h00, 0, 0, 8'hFB, "dx_fa");
    idle(8'hFB, "musx_wrap");
    apply_stimulus('0, 0, 8'h80, 0, 1, 0, 0, 8'h00, 0, 0, 8'hFF, "dy_80a");
    apply_stimulus('0, 0, 8'h80, 0, 1, 0, 0, 8'h00, 0, 0, 8'hFF, "dy_80b");
    idle(8'hFF, "musy_wrap");
    apply_stimulus('0, 0, 8'h37, 1, 1, 1, 1, 8'h00, 0, 0, 8'hFE, "all_mus_stb");
    idle(8'hFA, "btn_read");
    idle(8'hFB, "x_read");

    for (int i = 1; i <= DEPTH; i++) fifo_op(8'(i), 1, 0, "fill");
    fifo_op(8'd9, 1, 0, "push_full");
    fifo_op(8'h00, 0, 1, "pop_after_ovf");
    idle(8'hFF, "after_pop");
    fifo_op(8'd10, 1, 0, "refill");
    fifo_op(8'hAA, 1, 1, "push_pop_full");
    for (int i = 0; i < DEPTH; i++) fifo_op(8'h00, 0, 1, "drain");
    fifo_op(8'h00, 0, 1, "pop_empty");
    fifo_op(8'h5C, 1, 1, "push_pop_empty");
    idle(8'hFF, "after_pp_empty");

    for (int i = 0; i < 3; i++) fifo_op(8'(8'h20 + i), 1, 0, "queue3");
    @(posedge fclk);
    #1;
    rst_n = 1'b0; mus_btnstb = 1'b1; mus_in = 8'h12; mus_dxstb = 1'b1;
    ev_stb = 1'b1; ev_pop = 1'b1; zah = 8'hFE;
    model_reset();
    exp_q.push_back(model_outputs(8'hFE));
    name_q.push_back("async_reset");
    idle(8'hFB, "reset_held");
    rst_n = 1'b1;
    idle(8'hFE, "post_reset");

    for (int i = 0; i < 400; i++) begin
      logic es, ep;
      if (i < 200) begin
        es = ($urandom_range(0, 3) != 0); ep = ($urandom_range(0, 3) == 0);
      end else begin
        es = ($urandom_range(0, 3) == 0); ep = ($urandom_range(0, 3) != 0);
      end
      apply_stimulus({$urandom, $urandom}, ($urandom_range(0, 7) == 0),
                     8'($urandom), ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 7) == 0), 8'($urandom), es, ep,
                     8'($urandom), "random");
    end
    idle(8'hFF, "final");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge fclk);
    #1;
    if (exp_q.size() > 0) begin
      n_fails++;
      $display("[TB] FAIL drain_scoreboard got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/zkbdmus_ng.md
Name: zkbdmus_ng

Overview:
Next-generation keyboard, mouse and joystick data hub for the zports read path, clocked on fclk.
- Latches the key matrix, Kempston mouse, buttons and joystick state delivered by slavespi.
- Generalises the key matrix to ROWS x COLS.
- Turns mouse inputs into wrapping position accumulators fed by signed deltas.
- Adds a key-event FIFO with pop handshake and sticky overflow flag, so the Z80 can read buffered scan events.

Parameters:
ROWS, 8, key-matrix rows, one per address line zah[ROWS-1:0]; range 1..8
COLS, 5, key-matrix columns, equal to the kbd_data width; range 1..8
FIFO_DEPTH, 8, key-event FIFO entries; power of two, range 2..64

Ports:
fclk  in  1  system clock; all state changes on its rising edge
rst_n  in  1  asynchronous active-low reset
kbd_in  in  ROWS*COLS  key bits; bit index r + ROWS*c; 1 means pressed
kbd_stb  in  1  load kbd_in
mus_in  in  8  shared data bus for mouse and joystick
mus_dxstb  in  1  add mus_in, as a signed delta, to X
mus_dystb  in  1  add mus_in, as a signed delta, to Y
mus_btnstb  in  1  load mus_in into the button register
kj_stb  in  1  load mus_in[4:0] into the joystick register
ev_in  in  8  key-event byte
ev_stb  in  1  push ev_in into the FIFO
ev_pop  in  1  single-cycle pulse from zports after it reads ev_data
zah  in  8  Z80 A15..A8
kbd_data  out  COLS  keyboard column data, active-low
mus_data  out  8  selected mouse register
kj_data  out  5  joystick register
ev_data  out  8  FIFO head
ev_empty  out  1  FIFO holds no entries
ev_full  out  1  FIFO holds FIFO_DEPTH entries
ev_ovf  out  1  sticky flag: an event was dropped

Behaviour:
Reset (asynchronous, all registers):
- kbd=0, so kbd_data is all ones.
- musx=0, musy=0, musbtn=8'hFF, kj_data=0.
- FIFO: read and write pointers 0, count 0, ev_empty=1, ev_full=0, ev_ovf=0.
- Reset mid-push or mid-pop discards the FIFO contents.

Storage:
- Each strobe updates its register on the same edge; the new value is visible the cycle after the strobe.
- Simultaneous strobes are independent. mus_dxstb and mus_dystb in the same cycle both add the same mus_in.

Mouse accumulators:
- musx <= musx + mus_in, and likewise for Y, computed modulo 256.
- Examples: 8'hFF + 8'h02 = 8'h01; 8'h00 + 8'hFF = 8'hFF. No saturation.

Keyboard output (combinational):
- kbd_data[COLS-1-c] = 0 iff some row r has zah[r]=0 and key (r,c) is pressed.
- Column 0 maps to the MSB.
- zah bits at ROWS and above are ignored.

Mouse read mux (combinational):
- mus_data = musbtn when zah[0]=0.
- mus_data = musx when zah[0]=1 and zah[2]=0.
- mus_data = musy when zah[0]=1 and zah[2]=1.
- Port map: FADF = buttons, FBDF = X, FFDF = Y.

FIFO:
- ev_data = mem[rdptr] when not empty; 8'h00 when empty.
- Push alone: accepted if not full; wrptr and count increment; the entry is visible the next cycle.
- Push while full, without pop: entry dropped, contents unchanged, ev_ovf <= 1.
- Pop alone: accepted if not empty; rdptr increments, count decrements. Pop when empty is ignored.
- Push and pop together, not empty: both accepted, count unchanged. This holds when full, and no overflow is flagged.
- Push and pop together, empty: push only; the pop is ignored.
- Pointers wrap modulo FIFO_DEPTH.
- ev_ovf clears on any accepted pop, unless a dropped push occurs in that same cycle.
- ev_empty = (count==0) and ev_full = (count==FIFO_DEPTH), both decoded from a registered count.

Test Plan:
- Reset, then zah=8'h00 -> kbd_data=5'b11111, mus_data=8'hFF, kj_data=0, ev_empty=1, ev_data=8'h00.
- kbd_in bit 0 and bit 9 set, kbd_stb pulse; zah=8'hFE -> kbd_data=5'b01111; zah=8'hFD -> 5'b10111; zah=8'hFC -> 5'b00111.
- mus_dxstb with 8'h05, then with 8'hFA; zah=8'hFB -> mus_data=8'hFF; mus_dystb with 8'h80 twice; zah=8'hFF -> 8'h00.
- Push 1..8 (FIFO_DEPTH=8) -> ev_full=1; push 9 -> ev_ovf=1 and ev_data=1; pop -> ev_data=2, ev_ovf=0, ev_full=0.
- With FIFO full, push 8'hAA and pop in the same cycle -> count stays 8, ev_ovf=0, 8'hAA becomes the 8th entry; drain 8 pops -> ev_empty=1; a 9th pop changes nothing.
- Assert rst_n low with 3 entries queued and mus_btnstb active -> immediately ev_empty=1, musbtn=8'hFF, musx=0.
